if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline. It holds the program counter and drives the word address into the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register for the decode stage. It also honours decode-stage stalls and execute-stage redirects (branches and jumps).

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 45 ++++
 rtl/if_fetch_stage.sv | 76 +++++++
 tb/tb_if_fetch_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg: shared constants and pipeline-register types               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            valid;
  } ifid_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg: pipeline register with flush > hold > load priority        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST_P = NOP_INST
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold_i,
  input  logic  flush_i,
  input  ifid_t load_i,
  output ifid_t ifid_o
);

  ifid_t bubble;
  ifid_t ifid_q;
  ifid_t ifid_d;

  assign bubble = '{pc: '0, pc4: '0, inst: NOP_INST_P, valid: 1'b0};

  always_comb begin
    ifid_d = load_i;
    if (flush_i) begin
      ifid_d = bubble;
    end else if (hold_i) begin
      ifid_d = ifid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_q <= bubble;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_stage: PC register, next-PC selection and IF/ID capture      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  ifid_t       ifid_load;
  ifid_t       ifid;
  logic        unused_redirect_lsb;

  // Targets are word aligned; the byte-offset bits carry no meaning here.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign ifid_load = '{pc: pc_q, pc4: pc_plus4, inst: imem_data, valid: 1'b1};

  if_id_reg #(
    .NOP_INST_P (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (stall),
    .flush_i (redirect),
    .load_i  (ifid_load),
    .ifid_o  (ifid)
  );

  assign imem_addr  = {2'b00, pc_q[31:2]};
  assign pc         = pc_q;
  assign ifid_pc    = ifid.pc;
  assign ifid_pc4   = ifid.pc4;
  assign ifid_inst  = ifid.inst;
  assign ifid_valid = ifid.valid;

endmodule : if_fetch_stage
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_fetch_stage: directed vector bench for the fetch stage          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .pc          (pc),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4),
    .ifid_inst   (ifid_inst),
    .ifid_valid  (ifid_valid)
  );

  // Word k of instruction memory holds 0x1000_0000 + k.
  assign imem_data = 32'h1000_0000 + imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] ia;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] inst;
    logic        valid;
  } vec_t;

  localparam int NV = 23;
  localparam logic [31:0] NOP = 32'h0000_0013;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] rpc,
                              logic [31:0] p, logic [31:0] ia, logic [31:0] ipc,
                              logic [31:0] ipc4, logic [31:0] inst, logic v);
    vec_t t;
    t.rst_n = r; t.stall = s; t.redirect = d; t.rpc = rpc;
    t.pc = p; t.ia = ia; t.ipc = ipc; t.ipc4 = ipc4; t.inst = inst; t.valid = v;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " pc"},         pc,         v.pc);
    chk({tag, " imem_addr"},  imem_addr,  v.ia);
    chk({tag, " ifid_pc"},    ifid_pc,    v.ipc);
    chk({tag, " ifid_pc4"},   ifid_pc4,   v.ipc4);
    chk({tag, " ifid_inst"},  ifid_inst,  v.inst);
    chk({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, v.valid});
  endtask

  initial begin
    //                rst  stl  red  redirect_pc    pc             imem_addr      ifid_pc        ifid_pc4       ifid_inst      valid
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         NOP,           1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         NOP,           1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h4,         32'h1,         32'h0,         32'h4,         32'h1000_0000, 1'b1);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h8,         32'h2,         32'h4,         32'h8,         32'h1000_0001, 1'b1);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         32'h8,         32'h2,         32'h4,         32'h8,         32'h1000_0001, 1'b1);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         32'h8,         32'h2,         32'h4,         32'h8,         32'h1000_0001, 1'b1);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         32'h8,         32'h2,         32'h4,         32'h8,         32'h1000_0001, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'hC,         32'h3,         32'h8,         32'hC,         32'h1000_0002, 1'b1);
    vecs[8]  = mk(1'b1, 1'b0, 1'b1, 32'h40,        32'h40,        32'h10,        32'h0,         32'h0,         NOP,           1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h44,        32'h11,        32'h40,        32'h44,        32'h1000_0010, 1'b1);
    vecs[10] = mk(1'b1, 1'b1, 1'b1, 32'h47,        32'h44,        32'h11,        32'h0,         32'h0,         NOP,           1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h48,        32'h12,        32'h44,        32'h48,        32'h1000_0011, 1'b1);
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0,         32'h0,         NOP,           1'b0);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         32'h4FFF_FFFF, 1'b1);
    vecs[14] = mk(1'b1, 1'b0, 1'b1, 32'h100,       32'h100,       32'h40,        32'h0,         32'h0,         NOP,           1'b0);
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 32'h0,         32'h100,       32'h40,        32'h0,         32'h0,         NOP,           1'b0);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h104,       32'h41,        32'h100,       32'h104,       32'h1000_0040, 1'b1);
    vecs[17] = mk(1'b1, 1'b0, 1'b1, 32'h200,       32'h200,       32'h80,        32'h0,         32'h0,         NOP,           1'b0);
    vecs[18] = mk(1'b1, 1'b0, 1'b1, 32'h302,       32'h300,       32'hC0,        32'h0,         32'h0,         NOP,           1'b0);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h304,       32'hC1,        32'h300,       32'h304,       32'h1000_00C0, 1'b1);
    vecs[20] = mk(1'b0, 1'b1, 1'b1, 32'h500,       32'h0,         32'h0,         32'h0,         32'h0,         NOP,           1'b0);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         NOP,           1'b0);
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h4,         32'h1,         32'h0,         32'h4,         32'h1000_0000, 1'b1);

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    for (int i = 0; i < NV; i++) begin
      rst_n       = vecs[i].rst_n;
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Long stall: registered outputs stay frozen, then fetch picks up at pc=4.
    stall = 1'b1; redirect = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("stall%0d", k), vecs[22]);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk_all("resume", mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 32'h2, 32'h4, 32'h8, 32'h1000_0001, 1'b1));

    // imem_addr follows pc combinationally; a redirect request alone must not move it.
    redirect = 1'b1; redirect_pc = 32'h800;
    #2;
    chk("comb imem_addr pre-edge", imem_addr, 32'h2);
    @(posedge clk);
    #1;
    chk("comb imem_addr post-edge", imem_addr, 32'h200);
    redirect = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_if_fetch_stage
`default_nettype wire
